mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter: HALT_ON_ILLEGAL, 0, 1 = illegal opcode parks FSM in HALT; 0 = illegal opcode returns to FETCH.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 opcode  in  6  IR[31:26]; funct  in  6  IR[5:0]; both from the instruction register.
REQ-005 zero  in  1  ALU zero flag (result == 0), sampled combinationally in BRANCH.
REQ-006 mem_ready  in  1  memory completes the current request this cycle.
REQ-007 mem_req  out  1  memory access request, held high until mem_ready; mem_we  out  1  write qualifier; iord  out  1  0 = PC address, 1 = ALUOut address.
REQ-008 ir_write  out  1; pc_en  out  1; pc_src  out  2  (00 ALU result, 01 ALUOut, 10 jump target).
REQ-009 alu_op  out  3  ALU opcode (000 add, 001 sub, 010 and, 011 or, 100 not A, 101 set-less-than unsigned).
REQ-010 alu_src_a  out  1  (0 PC, 1 reg A); alu_src_b  out  2  (00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2).
REQ-011 reg_write  out  1; reg_dst  out  1  (1 = rd, 0 = rt); mem_to_reg  out  1  (1 = MDR).
REQ-012 illegal  out  1  one-cycle pulse on undecodable opcode/funct; state  out  4  current state, debug.

Function
REQ-013 The FSM SHALL have states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB, ADDIEX, ADDIWB, BRANCH, JUMP, HALT.
REQ-014 Outputs SHALL be Moore decodes of state, except ir_write/pc_en in FETCH (gated by mem_ready) and pc_en in BRANCH (= zero).
REQ-015 FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=00; ir_write=pc_en=mem_ready; advance to DECODE only when mem_ready=1.
REQ-016 DECODE: alu_src_a=0, alu_src_b=11, alu_op=000; next state by opcode: 0x00 RTEXEC, 0x23/0x2B MEMADR, 0x08 ADDIEX, 0x04 BRANCH, 0x02 JUMP, other = illegal.
REQ-017 RTEXEC: alu_src_a=1, alu_src_b=00; funct map 0x20->000, 0x22->001, 0x24->010, 0x25->011, 0x27->100, 0x2A->101; unmapped funct = illegal.
REQ-018 RTWB: reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
REQ-019 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=000; opcode 0x23 -> MEMRD, 0x2B -> MEMWR.
REQ-020 MEMRD/MEMWR: mem_req=1, iord=1, mem_we=1 only in MEMWR; hold until mem_ready; MEMRD -> MEMWB, MEMWR -> FETCH.
REQ-021 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; then FETCH.
REQ-022 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=000 -> ADDIWB (reg_write=1, reg_dst=0, mem_to_reg=0) -> FETCH.
REQ-023 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_src=01, pc_en=zero; then FETCH.
REQ-024 JUMP: pc_src=10, pc_en=1; then FETCH.
REQ-025 Illegal (DECODE or RTEXEC): illegal=1 that cycle, no write strobes; next FETCH, or HALT if HALT_ON_ILLEGAL=1; HALT exits only via reset.
REQ-026 Zero-wait latencies SHALL be: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3 cycles; each mem_ready=0 cycle adds one.
REQ-027 All inactive outputs SHALL be 0 in every state (mem_we never high without mem_req).

Reset
REQ-028 rst_n low SHALL force state=FETCH asynchronously; all write strobes (pc_en, ir_write, reg_write, mem_we) SHALL read 0 while rst_n is low, even mid-access.
REQ-029 After rst_n deasserts, first rising edge SHALL begin FETCH with mem_req=1.

Structure
REQ-030 State encodings, opcode/funct constants and the 3-bit ALU op codes SHALL live in a shared package (cpu_defs) used by mc_ctrl and the ALU.
REQ-031 The funct-to-alu_op decode SHALL be a sub-module alu_dec (combinational, outputs alu_op and valid).

Verification
REQ-032 R-type add, funct 0x20, mem_ready=1: states FETCH,DECODE,RTEXEC,RTWB; alu_op=000 in RTEXEC; reg_write=1, reg_dst=1 in cycle 4.
REQ-033 lw 0x23 with mem_ready low 2 cycles in MEMRD: MEMRD held 3 cycles, iord=1, mem_we=0; MEMWB asserts reg_write, mem_to_reg=1; total 7 cycles.
REQ-034 beq 0x04 with zero=1 then zero=0: pc_en=1, pc_src=01 in BRANCH first case; pc_en=0 second case.
REQ-035 opcode 0x3F, HALT_ON_ILLEGAL=0 then 1: illegal pulses one cycle; returns FETCH / sticks in HALT with all strobes 0.
REQ-036 rst_n asserted in MEMWR while mem_ready=0: mem_we drops immediately, state=FETCH; release -> normal fetch.
REQ-037 R-type funct 0x2A then 0x27: alu_op=101 then 100; funct 0x00: illegal=1, no reg_write.

Source files
------------

// File: rtl/cpu_defs.sv
// -----------------------------------------------------------------------------
// cpu_defs -- shared definitions for the multicycle CPU control path.
//   state_e   : controller state encoding (also exported on the debug port)
//   OP_* / FN_* : instruction opcode (IR[31:26]) and R-type funct (IR[5:0])
//   alu_op_e  : 3-bit ALU operation codes, shared by the controller and ALU
//   SRCB_* / PCSRC_* : datapath mux select encodings
// -----------------------------------------------------------------------------
package cpu_defs;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_RTEXEC = 4'd6,
    ST_RTWB   = 4'd7,
    ST_ADDIEX = 4'd8,
    ST_ADDIWB = 4'd9,
    ST_BRANCH = 4'd10,
    ST_JUMP   = 4'd11,
    ST_HALT   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_NOTA = 3'b100,
    ALU_SLTU = 3'b101
  } alu_op_e;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_if.sv
// -----------------------------------------------------------------------------
// mc_ctrl_if -- bundle between the multicycle controller and its datapath.
//   Datapath -> controller : opcode, funct, zero, mem_ready
//   Controller -> datapath : memory strobes (mem_req, mem_we, iord),
//                            PC/IR strobes (ir_write, pc_en, pc_src),
//                            ALU controls (alu_op, alu_src_a, alu_src_b),
//                            register file controls (reg_write, reg_dst,
//                            mem_to_reg), illegal pulse and debug state.
//   master : the controller side; slave : the datapath side.
// -----------------------------------------------------------------------------
interface mc_ctrl_if;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_write;
  logic       pc_en;
  logic [1:0] pc_src;
  logic [2:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_op,
           alu_src_a, alu_src_b, reg_write, reg_dst, mem_to_reg,
           illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_op,
           alu_src_a, alu_src_b, reg_write, reg_dst, mem_to_reg,
           illegal, state
  );

endinterface

// File: rtl/mc_ctrl_alu_dec.sv
// -----------------------------------------------------------------------------
// alu_dec -- combinational R-type funct decoder.
//   funct_i  : IR[5:0]
//   alu_op_o : ALU operation for the funct (ALU_ADD when unmapped)
//   valid_o  : 1 when funct is one of the supported R-type operations
// -----------------------------------------------------------------------------
module alu_dec
  import cpu_defs::*;
(
  input  logic [5:0] funct_i,
  output alu_op_e    alu_op_o,
  output logic       valid_o
);

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned; otherwise synthesis infers a latch.
  always_comb begin
    alu_op_o = ALU_ADD;
    valid_o  = 1'b1;
    case (funct_i)
      FN_ADD:  alu_op_o = ALU_ADD;
      FN_SUB:  alu_op_o = ALU_SUB;
      FN_AND:  alu_op_o = ALU_AND;
      FN_OR:   alu_op_o = ALU_OR;
      FN_NOR:  alu_op_o = ALU_NOTA;
      FN_SLT:  alu_op_o = ALU_SLTU;
      default: valid_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl -- multicycle MIPS-style controller FSM.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (forces FETCH, silences strobes)
//   bus   : mc_ctrl_if.master (instruction fields, ALU zero, memory handshake
//           in; datapath controls, illegal pulse and debug state out)
//   HALT_ON_ILLEGAL : 1 parks the FSM in HALT on an undecodable instruction,
//                     0 resumes at FETCH.
// Outputs are decoded from the current state; the only input-dependent ones
// are the FETCH strobes (mem_ready), pc_en in BRANCH (zero), the RTEXEC ALU
// op (funct) and the illegal pulse.
// -----------------------------------------------------------------------------
module mc_ctrl
  import cpu_defs::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic      clk,
  input  logic      rst_n,
  mc_ctrl_if.master bus
);

  localparam state_e ILLEGAL_NEXT = HALT_ON_ILLEGAL ? ST_HALT : ST_FETCH;

  state_e     state_q, state_d;

  alu_op_e    rt_alu_op;
  logic       rt_valid;

  logic       mem_req_c, mem_we_c, iord_c, ir_write_c, pc_en_c;
  logic [1:0] pc_src_c;
  alu_op_e    alu_op_c;
  logic       alu_src_a_c;
  logic [1:0] alu_src_b_c;
  logic       reg_write_c, reg_dst_c, mem_to_reg_c, illegal_c;

  alu_dec u_alu_dec (
    .funct_i  (bus.funct),
    .alu_op_o (rt_alu_op),
    .valid_o  (rt_valid)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    iord_c       = 1'b0;
    ir_write_c   = 1'b0;
    pc_en_c      = 1'b0;
    pc_src_c     = PCSRC_ALU;
    alu_op_c     = ALU_ADD;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = SRCB_REGB;
    reg_write_c  = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    illegal_c    = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        // PC + 4 is computed while the instruction word is being read; both
        // IR and PC commit only on the cycle memory delivers.
        mem_req_c   = 1'b1;
        alu_src_b_c = SRCB_FOUR;
        ir_write_c  = bus.mem_ready;
        pc_en_c     = bus.mem_ready;
        if (bus.mem_ready) state_d = ST_DECODE;
      end

      ST_DECODE: begin
        // Speculative branch target PC + (imm << 2) lands in ALUOut.
        alu_src_b_c = SRCB_IMM_SH2;
        case (bus.opcode)
          OP_RTYPE:     state_d = ST_RTEXEC;
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          default: begin
            illegal_c = 1'b1;
            state_d   = ILLEGAL_NEXT;
          end
        endcase
      end

      ST_MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        if (bus.opcode == OP_LW)      state_d = ST_MEMRD;
        else if (bus.opcode == OP_SW) state_d = ST_MEMWR;
        else                          state_d = ST_FETCH;
      end

      ST_MEMRD: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        if (bus.mem_ready) state_d = ST_MEMWB;
      end

      ST_MEMWR: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        iord_c    = 1'b1;
        if (bus.mem_ready) state_d = ST_FETCH;
      end

      ST_MEMWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        state_d      = ST_FETCH;
      end

      ST_RTEXEC: begin
        alu_src_a_c = 1'b1;
        if (rt_valid) begin
          alu_op_c = rt_alu_op;
          state_d  = ST_RTWB;
        end else begin
          illegal_c = 1'b1;
          state_d   = ILLEGAL_NEXT;
        end
      end

      ST_RTWB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
        state_d     = ST_FETCH;
      end

      ST_ADDIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        state_d     = ST_ADDIWB;
      end

      ST_ADDIWB: begin
        reg_write_c = 1'b1;
        state_d     = ST_FETCH;
      end

      ST_BRANCH: begin
        // A - B feeds the zero flag; the target computed in DECODE is taken
        // from ALUOut only when the operands are equal.
        alu_src_a_c = 1'b1;
        alu_op_c    = ALU_SUB;
        pc_src_c    = PCSRC_ALUOUT;
        pc_en_c     = bus.zero;
        state_d     = ST_FETCH;
      end

      ST_JUMP: begin
        pc_src_c = PCSRC_JUMP;
        pc_en_c  = 1'b1;
        state_d  = ST_FETCH;
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_FETCH;
    endcase
  end

  // FETCH is the reset state and its strobes follow mem_ready, so the write
  // and request strobes are additionally qualified by rst_n to stay quiet
  // for the whole time reset is held.
  assign bus.mem_req    = mem_req_c   & rst_n;
  assign bus.mem_we     = mem_we_c    & rst_n;
  assign bus.ir_write   = ir_write_c  & rst_n;
  assign bus.pc_en      = pc_en_c     & rst_n;
  assign bus.reg_write  = reg_write_c & rst_n;

  assign bus.iord       = iord_c;
  assign bus.pc_src     = pc_src_c;
  assign bus.alu_op     = alu_op_c;
  assign bus.alu_src_a  = alu_src_a_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.reg_dst    = reg_dst_c;
  assign bus.mem_to_reg = mem_to_reg_c;
  assign bus.illegal    = illegal_c;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl -- scoreboard bench for mc_ctrl.
// Two controllers (HALT_ON_ILLEGAL = 0 and 1) see the same instruction
// stream. For each instruction the reference model expands its execution
// phases (fetch with stalls, decode, execute, memory with stalls, writeback)
// into per-cycle expected control words and pushes them to a queue; a monitor
// pops one entry per cycle on the falling edge and compares both DUTs.
// -----------------------------------------------------------------------------
module tb_mc_ctrl;
  import cpu_defs::*;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic [3:0] state;
  } ctl_t;

  typedef struct {
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    ctl_t       e0;
    ctl_t       e1;
  } item_t;

  typedef struct packed {
    ctl_t e0;
    ctl_t e1;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  exp_t  exp_q[$];
  item_t items[$];
  bit    halted1 = 1'b0;
  logic [5:0] cur_op, cur_fn;
  logic       cur_zero;

  always #5 clk = ~clk;

  mc_ctrl_if bus0 ();
  mc_ctrl_if bus1 ();

  assign bus0.opcode = opcode;    assign bus1.opcode = opcode;
  assign bus0.funct = funct;      assign bus1.funct = funct;
  assign bus0.zero = zero;        assign bus1.zero = zero;
  assign bus0.mem_ready = mem_ready;
  assign bus1.mem_ready = mem_ready;

  mc_ctrl #(.HALT_ON_ILLEGAL(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mc_ctrl #(.HALT_ON_ILLEGAL(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  ctl_t act0, act1;
  assign act0 = {bus0.mem_req, bus0.mem_we, bus0.iord, bus0.ir_write, bus0.pc_en,
                 bus0.pc_src, bus0.alu_op, bus0.alu_src_a, bus0.alu_src_b,
                 bus0.reg_write, bus0.reg_dst, bus0.mem_to_reg, bus0.illegal,
                 bus0.state};
  assign act1 = {bus1.mem_req, bus1.mem_we, bus1.iord, bus1.ir_write, bus1.pc_en,
                 bus1.pc_src, bus1.alu_op, bus1.alu_src_a, bus1.alu_src_b,
                 bus1.reg_write, bus1.reg_dst, bus1.mem_to_reg, bus1.illegal,
                 bus1.state};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected control word per clock cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("dut0_ctl", 32'(act0), 32'(e.e0));
        check("dut1_ctl", 32'(act1), 32'(e.e1));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic ctl_t blank(input state_e s);
    ctl_t c;
    c = '0;
    c.state = s;
    return c;
  endfunction

  function automatic bit funct_lookup(input logic [5:0] f, output logic [2:0] op);
    logic [5:0] tab [6];
    tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    op = 3'b000;
    for (int i = 0; i < 6; i++)
      if (tab[i] == f) begin
        op = 3'(i);
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic bit opcode_known(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J};
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // The HALT_ON_ILLEGAL=1 controller matches the other one until its first
  // illegal pulse, after which it reads HALT with everything low.
  task automatic push_item(input ctl_t e, input logic mr);
    item_t it;
    it.opcode = cur_op;
    it.funct = cur_fn;
    it.zero = cur_zero;
    it.mem_ready = mr;
    it.e0 = e;
    it.e1 = halted1 ? blank(ST_HALT) : e;
    if (!halted1 && e.illegal) halted1 = 1'b1;
    items.push_back(it);
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int sf, input int sm);
    ctl_t c;
    logic [2:0] aop;
    cur_op = op;
    cur_fn = fn;
    cur_zero = z;
    for (int i = 0; i <= sf; i++) begin
      c = blank(ST_FETCH);
      c.mem_req = 1'b1;
      c.alu_src_b = 2'b01;
      c.ir_write = (i == sf);
      c.pc_en = (i == sf);
      push_item(c, (i == sf));
    end
    c = blank(ST_DECODE);
    c.alu_src_b = 2'b11;
    if (!opcode_known(op)) begin
      c.illegal = 1'b1;
      push_item(c, rnd_bit());
      return;
    end
    push_item(c, rnd_bit());
    case (op)
      OP_RTYPE: begin
        c = blank(ST_RTEXEC);
        c.alu_src_a = 1'b1;
        if (funct_lookup(fn, aop)) begin
          c.alu_op = aop;
          push_item(c, rnd_bit());
          c = blank(ST_RTWB);
          c.reg_write = 1'b1;
          c.reg_dst = 1'b1;
          push_item(c, rnd_bit());
        end else begin
          c.illegal = 1'b1;
          push_item(c, rnd_bit());
        end
      end
      OP_LW, OP_SW: begin
        c = blank(ST_MEMADR);
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        push_item(c, rnd_bit());
        for (int i = 0; i <= sm; i++) begin
          c = blank(op == OP_LW ? ST_MEMRD : ST_MEMWR);
          c.mem_req = 1'b1;
          c.iord = 1'b1;
          c.mem_we = (op == OP_SW);
          push_item(c, (i == sm));
        end
        if (op == OP_LW) begin
          c = blank(ST_MEMWB);
          c.reg_write = 1'b1;
          c.mem_to_reg = 1'b1;
          push_item(c, rnd_bit());
        end
      end
      OP_ADDI: begin
        c = blank(ST_ADDIEX);
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        push_item(c, rnd_bit());
        c = blank(ST_ADDIWB);
        c.reg_write = 1'b1;
        push_item(c, rnd_bit());
      end
      OP_BEQ: begin
        c = blank(ST_BRANCH);
        c.alu_src_a = 1'b1;
        c.alu_op = 3'b001;
        c.pc_src = 2'b01;
        c.pc_en = z;
        push_item(c, rnd_bit());
      end
      default: begin
        c = blank(ST_JUMP);
        c.pc_src = 2'b10;
        c.pc_en = 1'b1;
        push_item(c, rnd_bit());
      end
    endcase
  endtask

  task automatic issue_one();
    item_t it;
    exp_t e;
    it = items.pop_front();
    @(posedge clk);
    #1;
    opcode = it.opcode;
    funct = it.funct;
    zero = it.zero;
    mem_ready = it.mem_ready;
    e.e0 = it.e0;
    e.e1 = it.e1;
    exp_q.push_back(e);
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input int sf, input int sm);
    build(op, fn, z, sf, sm);
    while (items.size() > 0) issue_one();
  endtask

  task automatic run_random(input int n);
    logic [5:0] op, fn;
    int k;
    logic [5:0] legal_fn [6];
    legal_fn = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT};
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 39);
      fn = legal_fn[$urandom_range(0, 5)];
      if (k < 10)      op = OP_RTYPE;
      else if (k < 16) op = OP_LW;
      else if (k < 21) op = OP_SW;
      else if (k < 26) op = OP_ADDI;
      else if (k < 32) op = OP_BEQ;
      else if (k < 36) op = OP_J;
      else if (k < 38) begin
        op = OP_RTYPE;
        fn = 6'($urandom);
      end else begin
        do op = 6'($urandom); while (opcode_known(op));
      end
      run(op, fn, rnd_bit(), $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #2;
    check("rst_state0", 32'(bus0.state), 32'(ST_FETCH));
    check("rst_state1", 32'(bus1.state), 32'(ST_FETCH));
    check("rst_ir_write", 32'(bus0.ir_write), 32'd0);
    check("rst_pc_en", 32'(bus0.pc_en), 32'd0);
    check("rst_reg_write", 32'(bus0.reg_write), 32'd0);
    repeat (2) @(posedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run(OP_RTYPE, FN_ADD, 1'b0, 0, 0);
    run(OP_LW, FN_ADD, 1'b0, 0, 2);
    run(OP_SW, FN_ADD, 1'b1, 1, 0);
    run(OP_ADDI, FN_ADD, 1'b0, 0, 0);
    run(OP_BEQ, FN_ADD, 1'b1, 0, 0);
    run(OP_BEQ, FN_ADD, 1'b0, 0, 0);
    run(OP_J, FN_ADD, 1'b0, 0, 0);
    run(OP_RTYPE, FN_SLT, 1'b0, 0, 0);
    run(OP_RTYPE, FN_NOR, 1'b0, 0, 0);
    run(OP_RTYPE, 6'h00, 1'b0, 0, 0);
    run(6'h3F, FN_ADD, 1'b0, 0, 0);
    run(OP_RTYPE, FN_SUB, 1'b0, 0, 0);
    run_random(150);

    // Reset in the middle of a stalled store.
    build(OP_SW, FN_ADD, 1'b0, 0, 5);
    for (int k = 0; k < 4; k++) issue_one();
    items.delete();
    @(negedge clk);
    #1;
    check("memwr_active_we", 32'(bus0.mem_we), 32'd1);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("memwr_rst_we", 32'(bus0.mem_we), 32'd0);
    check("memwr_rst_state0", 32'(bus0.state), 32'(ST_FETCH));
    check("memwr_rst_state1", 32'(bus1.state), 32'(ST_FETCH));
    check("memwr_rst_ir_write", 32'(bus0.ir_write), 32'd0);
    check("memwr_rst_pc_en", 32'(bus0.pc_en), 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_state0", 32'(bus0.state), 32'(ST_FETCH));
    check("rst_hold_pc_en", 32'(bus0.pc_en), 32'd0);
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    halted1 = 1'b0;

    run(OP_LW, FN_ADD, 1'b0, 2, 1);
    run(6'h3F, FN_ADD, 1'b0, 0, 0);
    run_random(150);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
